// File: rtl/ram_cmd_arbiter_if.sv
// Requester handshake, response and RAM command-stream signals for ram_cmd_arbiter.
// The arbiter sits on the slave modport; the requesters and RAM drive the master side.
interface ram_cmd_arbiter_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic                 req0_we;
    logic [ADDR_SIZE-1:0] req0_addr;
    logic [7:0]           req0_wdata;
    logic                 rsp0_valid;
    logic [7:0]           rsp0_rdata;
    logic                 rsp0_err;

    logic                 req1_valid;
    logic                 req1_ready;
    logic                 req1_we;
    logic [ADDR_SIZE-1:0] req1_addr;
    logic [7:0]           req1_wdata;
    logic                 rsp1_valid;
    logic [7:0]           rsp1_rdata;
    logic                 rsp1_err;

    logic                 ram_rx_valid;
    logic [9:0]           ram_din;
    logic                 ram_tx_valid;
    logic [7:0]           ram_dout;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  ram_tx_valid, ram_dout,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output ram_rx_valid, ram_din
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output ram_tx_valid, ram_dout,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  ram_rx_valid, ram_din
    );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// Two-requester round-robin arbiter that turns read/write transactions into the
// single-port RAM's 10-bit command stream, skipping address commands on pointer hits.
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE  = 8,
    parameter int ADDR_CACHE = 1,
    parameter int TIMEOUT    = 4
) (
    input  logic             clk,
    input  logic             rst,
    ram_cmd_arbiter_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, RADDR, RCMD, RWAIT, RESP} state_t;

    typedef struct packed {
        logic                 id;
        logic                 we;
        logic [ADDR_SIZE-1:0] addr;
        logic [7:0]           wdata;
    } txn_t;

    typedef struct packed {
        logic       vld;
        logic [9:0] din;
    } cmd_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    function automatic logic [7:0] zext(input logic [ADDR_SIZE-1:0] a);
        return 8'(a);
    endfunction

    state_t               state_q, state_d;
    txn_t                 txn_q, txn_d;
    cmd_t                 cmd_q, cmd_d;
    rsp_t                 rsp_q, rsp_d;
    logic                 last_grant_q, last_grant_d;
    logic [ADDR_SIZE-1:0] wptr_q, rptr_q;
    logic                 wptr_vld_q, rptr_vld_q;
    logic [CW-1:0]        cnt_q;
    logic                 cnt_clr, cnt_inc, rptr_drop;
    logic [1:0]           req_valid, ready;
    logic                 gnt_id, whit, rhit;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    // On contention the requester that did not win last time gets the grant.
    assign gnt_id    = (&req_valid) ? ~last_grant_q : req_valid[1];

    always_comb begin
        state_d      = state_q;
        txn_d        = txn_q;
        cmd_d        = '0;
        rsp_d        = '0;
        last_grant_d = last_grant_q;
        ready        = '0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        rptr_drop    = 1'b0;
        whit         = 1'b0;
        rhit         = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|req_valid) && !rst) begin
                    ready[gnt_id] = 1'b1;
                    last_grant_d  = gnt_id;
                    txn_d.id      = gnt_id;
                    txn_d.we      = gnt_id ? bus.req1_we    : bus.req0_we;
                    txn_d.addr    = gnt_id ? bus.req1_addr  : bus.req0_addr;
                    txn_d.wdata   = gnt_id ? bus.req1_wdata : bus.req0_wdata;
                    whit = (ADDR_CACHE != 0) && wptr_vld_q && (wptr_q == txn_d.addr);
                    rhit = (ADDR_CACHE != 0) && rptr_vld_q && (rptr_q == txn_d.addr);
                    // Command words are registered here so the RAM sees them in the next state.
                    cmd_d.vld = 1'b1;
                    if (txn_d.we) begin
                        if (whit) begin
                            state_d   = WDATA;
                            cmd_d.din = {2'b01, txn_d.wdata};
                        end else begin
                            state_d   = WADDR;
                            cmd_d.din = {2'b00, zext(txn_d.addr)};
                        end
                    end else begin
                        if (rhit) begin
                            state_d   = RCMD;
                            cmd_d.din = {2'b11, 8'h00};
                        end else begin
                            state_d   = RADDR;
                            cmd_d.din = {2'b10, zext(txn_d.addr)};
                        end
                    end
                end
            end
            WADDR: begin
                state_d   = WDATA;
                cmd_d.vld = 1'b1;
                cmd_d.din = {2'b01, txn_q.wdata};
            end
            WDATA: begin
                state_d   = RESP;
                rsp_d.vld = 1'b1;
            end
            RADDR: begin
                state_d   = RCMD;
                cmd_d.vld = 1'b1;
                cmd_d.din = {2'b11, 8'h00};
            end
            RCMD: begin
                state_d = RWAIT;
                cnt_clr = 1'b1;
            end
            RWAIT: begin
                if (bus.ram_tx_valid) begin
                    state_d     = RESP;
                    rsp_d.vld   = 1'b1;
                    rsp_d.rdata = bus.ram_dout;
                end else if (cnt_q == CNT_LAST) begin
                    // The RAM's read pointer is no longer trusted after a lost read.
                    state_d   = RESP;
                    rsp_d.vld = 1'b1;
                    rsp_d.err = 1'b1;
                    rptr_drop = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            txn_q        <= '0;
            cmd_q        <= '0;
            rsp_q        <= '0;
            last_grant_q <= 1'b1;
            wptr_q       <= '0;
            rptr_q       <= '0;
            wptr_vld_q   <= 1'b0;
            rptr_vld_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            txn_q        <= txn_d;
            cmd_q        <= cmd_d;
            rsp_q        <= rsp_d;
            last_grant_q <= last_grant_d;
            if (state_q == WADDR) begin
                wptr_q     <= txn_q.addr;
                wptr_vld_q <= 1'b1;
            end
            if (state_q == RADDR) begin
                rptr_q     <= txn_q.addr;
                rptr_vld_q <= 1'b1;
            end else if (rptr_drop) begin
                rptr_vld_q <= 1'b0;
            end
            if (cnt_clr)
                cnt_q <= '0;
            else if (cnt_inc)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.req0_ready   = ready[0];
    assign bus.req1_ready   = ready[1];
    assign bus.ram_rx_valid = cmd_q.vld;
    assign bus.ram_din      = cmd_q.din;

    assign bus.rsp0_valid = rsp_q.vld & ~txn_q.id;
    assign bus.rsp1_valid = rsp_q.vld &  txn_q.id;
    assign bus.rsp0_rdata = (bus.rsp0_valid && !txn_q.we) ? rsp_q.rdata : 8'h00;
    assign bus.rsp1_rdata = (bus.rsp1_valid && !txn_q.we) ? rsp_q.rdata : 8'h00;
    assign bus.rsp0_err   = bus.rsp0_valid & rsp_q.err;
    assign bus.rsp1_err   = bus.rsp1_valid & rsp_q.err;
endmodule
